// File: rtl/ising_run_ctrl_if.sv
// rtl/ising_run_ctrl_if.sv - run control, spin capture and weight-write gating signals of ising_run_ctrl
interface ising_run_ctrl_if #(
  parameter int N     = 8,
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] run_cycles;
  logic             busy;
  logic             done;
  logic [N-1:0]     spins;
  logic             ising_rstn;
  logic [N-1:0]     osc_out;
  logic             host_wready;
  logic             mat_wready;
  logic             wr_blocked;

  modport master (
    output start, abort, run_cycles, osc_out, host_wready,
    input  busy, done, spins, ising_rstn, mat_wready, wr_blocked
  );

  modport slave (
    input  start, abort, run_cycles, osc_out, host_wready,
    output busy, done, spins, ising_rstn, mat_wready, wr_blocked
  );
endinterface

// File: rtl/ising_run_ctrl.sv
// rtl/ising_run_ctrl.sv - run sequencer for the oscillator matrix; ISING_MAJORITY_EN enables multi-snapshot majority capture
module ising_run_ctrl #(
  parameter int N           = 8,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLES     = 3,
  parameter int SAMPLE_GAP  = 4
) (
  input logic clk,
  input logic axi_rstn,
  ising_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, SAMPLE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] r_len, r_len_nxt;
  logic             rstn_q, rstn_nxt;
  logic             done_q, done_nxt;
  logic [N-1:0]     spins_q, spins_nxt;
  logic             wr_blocked_q;
  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     osc_s;
  logic             start_ok;

  assign osc_s    = sync_q[SYNC_STAGES-1];
  assign start_ok = bus.start && !bus.abort;

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.spins      = spins_q;
  assign bus.ising_rstn = rstn_q;
  assign bus.wr_blocked = wr_blocked_q;
  assign bus.mat_wready = bus.host_wready && (state == IDLE);

`ifdef ISING_MAJORITY_EN
  localparam int OW = $clog2(SAMPLES + 1);
  localparam logic [CNT_W-1:0] SAMPLE_LEN = CNT_W'((SAMPLES - 1) * SAMPLE_GAP);

  logic [OW-1:0]    ones_q [N];
  logic [OW-1:0]    ones_nxt [N];
  logic [CNT_W-1:0] gap_q, gap_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    r_len_nxt = r_len;
    rstn_nxt  = rstn_q;
    done_nxt  = done_q;
    spins_nxt = spins_q;
`ifdef ISING_MAJORITY_EN
    gap_nxt   = gap_q;
    ones_nxt  = ones_q;
`endif
    case (state)
      IDLE: begin
        rstn_nxt = 1'b0;
        if (start_ok) begin
          done_nxt  = 1'b0;
          r_len_nxt = (bus.run_cycles == '0) ? CNT_W'(1) : bus.run_cycles;
          cnt_nxt   = CNT_W'(RST_CYCLES - 1);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          rstn_nxt  = 1'b0;
        end else if (cnt == '0) begin
          rstn_nxt  = 1'b1;
          cnt_nxt   = r_len - CNT_W'(1);
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          rstn_nxt  = 1'b0;
        end else if (cnt == '0) begin
          state_nxt = SAMPLE;
`ifdef ISING_MAJORITY_EN
          cnt_nxt = SAMPLE_LEN;
          gap_nxt = '0;
          for (int i = 0; i < N; i++) ones_nxt[i] = '0;
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          rstn_nxt  = 1'b0;
`ifdef ISING_MAJORITY_EN
          for (int i = 0; i < N; i++) ones_nxt[i] = '0;
`endif
        end else begin
`ifdef ISING_MAJORITY_EN
          // cnt and gap_q stay aligned, so the last window always ends on a snapshot cycle
          if (gap_q == '0) begin
            if (cnt == '0) begin
              for (int i = 0; i < N; i++)
                spins_nxt[i] = (int'(ones_q[i]) + int'(osc_s[i])) > (SAMPLES / 2);
              done_nxt  = 1'b1;
              rstn_nxt  = 1'b0;
              state_nxt = IDLE;
            end else begin
              for (int i = 0; i < N; i++) ones_nxt[i] = ones_q[i] + OW'(osc_s[i]);
              gap_nxt = CNT_W'(SAMPLE_GAP - 1);
            end
          end else begin
            gap_nxt = gap_q - CNT_W'(1);
          end
          if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
`else
          spins_nxt = osc_s;
          done_nxt  = 1'b1;
          rstn_nxt  = 1'b0;
          state_nxt = IDLE;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        rstn_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      r_len        <= '0;
      rstn_q       <= 1'b0;
      done_q       <= 1'b0;
      spins_q      <= '0;
      wr_blocked_q <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
`ifdef ISING_MAJORITY_EN
      gap_q <= '0;
      for (int i = 0; i < N; i++) ones_q[i] <= '0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      r_len        <= r_len_nxt;
      rstn_q       <= rstn_nxt;
      done_q       <= done_nxt;
      spins_q      <= spins_nxt;
      wr_blocked_q <= bus.host_wready && (state != IDLE);
      sync_q[0]    <= bus.osc_out;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
`ifdef ISING_MAJORITY_EN
      gap_q  <= gap_nxt;
      ones_q <= ones_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// tb/tb_ising_run_ctrl.sv - randomized self-checking bench for ising_run_ctrl against a run-timeline model
`timescale 1ns/1ps
module tb_ising_run_ctrl;
  localparam int N     = 8;
  localparam int CNT_W = 32;
  localparam int RST   = 16;
  localparam int SS    = 2;
  localparam int GAP   = 4;
`ifdef ISING_MAJORITY_EN
  localparam int NSNAP = 3;
`else
  localparam int NSNAP = 1;
`endif
  localparam int EXTRA = (NSNAP - 1) * GAP;

  logic clk = 1'b0;
  logic axi_rstn = 1'b0;
  always #5 clk = ~clk;

  ising_run_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

  ising_run_ctrl #(
    .N(N), .CNT_W(CNT_W), .RST_CYCLES(RST), .SYNC_STAGES(SS),
    .SAMPLES(3), .SAMPLE_GAP(GAP)
  ) dut (
    .clk(clk),
    .axi_rstn(axi_rstn),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [N-1:0] model_spins = '0;
  logic         model_done = 1'b0;
  logic [N-1:0] pat [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] majority();
    logic [N-1:0] r;
    for (int b = 0; b < N; b++) begin
      int ones = 0;
      for (int s = 0; s < NSNAP; s++) ones += int'(pat[s][b]);
      r[b] = (ones > NSNAP / 2);
    end
    return r;
  endfunction

  // Edge k=0 accepts start; outputs after edge k follow from the run's arithmetic timeline.
  task automatic run(input int rc, input int abort_k, input int dup_k);
    int R, T, stop, first_snap, e, idx;
    logic [N-1:0] exp_sp;
    logic busy_before, prev_host, b_exp;
    R          = (rc == 0) ? 1 : rc;
    T          = RST + R + 1 + EXTRA;
    stop       = (abort_k >= 0) ? abort_k : T;
    first_snap = RST + R + 1;
    exp_sp     = majority();
    prev_host  = 1'b0;
    bus.run_cycles = CNT_W'(rc);
    for (int k = 0; k <= T + 2; k++) begin
      bus.start = (k == 0) || (k == dup_k);
      bus.abort = (k == abort_k);
      if (k == dup_k) bus.run_cycles = CNT_W'($urandom_range(0, 3));
      bus.host_wready = 1'($urandom_range(0, 1));
      e = k + SS;
      idx = (e < first_snap) ? 0 : (e - first_snap) / GAP;
      if (idx > NSNAP - 1) idx = NSNAP - 1;
      bus.osc_out = pat[idx];
      busy_before = (k >= 1) && (k - 1 < stop);
      #1;
      chk("mat_wready", 64'(bus.mat_wready), 64'(bus.host_wready && !busy_before));
      prev_host = bus.host_wready;
      @(posedge clk);
      @(negedge clk);
      b_exp = (k < stop);
      chk("busy", 64'(bus.busy), 64'(b_exp));
      chk("ising_rstn", 64'(bus.ising_rstn), 64'((k >= RST) && (k < stop)));
      chk("done", 64'(bus.done), 64'((abort_k < 0) && (k >= T)));
      chk("spins", 64'(bus.spins), 64'(((abort_k < 0) && (k >= T)) ? exp_sp : model_spins));
      chk("wr_blocked", 64'(bus.wr_blocked), 64'(prev_host && busy_before));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.host_wready = 1'b0;
    model_done = (abort_k < 0);
    if (abort_k < 0) model_spins = exp_sp;
  endtask

  initial begin
    int rc, T, ak, dk;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.run_cycles = '0;
    bus.osc_out = '0;
    bus.host_wready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_spins", 64'(bus.spins), 64'(0));
    chk("rst_ising_rstn", 64'(bus.ising_rstn), 64'(0));
    chk("rst_wr_blocked", 64'(bus.wr_blocked), 64'(0));
    axi_rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 3; s++) pat[s] = 8'hA5;
    run(100, -1, -1);
    chk("t1_spins", 64'(bus.spins), 64'(8'hA5));

    for (int s = 0; s < 3; s++) pat[s] = 8'h3C;
    run(0, -1, RST + 1);

    for (int s = 0; s < 3; s++) pat[s] = 8'h5A;
    run(100, RST + 50, -1);
    chk("t3_spins_kept", 64'(bus.spins), 64'(8'h3C));

    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.run_cycles = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 64'(bus.busy), 64'(0));
    chk("start_abort_rstn", 64'(bus.ising_rstn), 64'(0));
    chk("start_abort_done", 64'(bus.done), 64'(model_done));

    bus.run_cycles = 32'd60;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.host_wready = 1'b1;
    repeat (30) @(posedge clk);
    #3 axi_rstn = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_done", 64'(bus.done), 64'(0));
    chk("arst_spins", 64'(bus.spins), 64'(0));
    chk("arst_rstn", 64'(bus.ising_rstn), 64'(0));
    chk("arst_wr_blocked", 64'(bus.wr_blocked), 64'(0));
    bus.host_wready = 1'b0;
    @(negedge clk);
    axi_rstn = 1'b1;
    model_spins = '0;
    model_done = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) pat[s] = 8'hC3;
    run(20, -1, -1);

`ifdef ISING_MAJORITY_EN
    pat[0] = 8'b1111_0001;
    pat[1] = 8'b0000_0010;
    pat[2] = 8'b1010_0101;
    run(10, -1, -1);
    chk("maj_spins10", 64'(bus.spins[1:0]), 64'(2'b01));
`endif

    for (int it = 0; it < 10; it++) begin
      rc = $urandom_range(0, 30);
      T = RST + ((rc == 0) ? 1 : rc) + 1 + EXTRA;
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, T) : -1;
      dk = ($urandom_range(0, 1) == 0) ? $urandom_range(1, T - 1) : -1;
      if (ak >= 0 && dk >= ak) dk = -1;
      for (int s = 0; s < 3; s++) pat[s] = N'($urandom);
      run(rc, ak, dk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ising_run_ctrl.md
Name: ising_run_ctrl

Overview:
Run sequencer for the coupled-oscillator core matrix.
- Owns the matrix's `ising_rstn`. Holds the oscillators in reset while idle so weights can be programmed.
- On command, releases the oscillators for a programmed number of clock cycles, then snapshots the synchronized spin outputs into a register.
- Also gates host weight writes so that no coupling weight changes while the array is running.

Parameters:
- N, 8, number of spins / oscillator outputs of the core matrix.
- CNT_W, 32, width of the run-length counter and the `run_cycles` input.
- RST_CYCLES, 16, cycles `ising_rstn` is held low at the start of each run (must be ≥1).
- SYNC_STAGES, 2, flip-flop stages in the oscillator-output synchronizer (must be ≥2).
- SAMPLES, 3, snapshots taken per run. Used only with ISING_MAJORITY_EN. Must be odd and ≥1.
- SAMPLE_GAP, 4, cycles between snapshots. Used only with ISING_MAJORITY_EN. Must be ≥1.

Ports:
- clk  in  1  system clock (same clock as the weight write bus).
- axi_rstn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle run request.
- abort  in  1  single-cycle abort request.
- run_cycles  in  CNT_W  free-run length in clk cycles, latched on an accepted start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  sticky run-complete flag.
- spins  out  N  last captured spin vector.
- ising_rstn  out  1  registered reset to the core matrix (active-low).
- osc_out  in  N  asynchronous oscillator outputs from the core matrix.
- host_wready  in  1  host weight-write strobe.
- mat_wready  out  1  gated write strobe forwarded to the matrix.
- wr_blocked  out  1  registered one-cycle pulse: a host write was dropped.

Behaviour:
- Reset (`axi_rstn`=0, asynchronous):
  - state=IDLE.
  - `ising_rstn`=0, `busy`=0, `done`=0, `spins`=0, `wr_blocked`=0.
  - Synchronizer flops cleared.
  - Counters cleared.
- Synchronizer: `osc_out` passes through SYNC_STAGES flops, clocked every cycle regardless of state. Only the last stage is ever sampled.
- States: IDLE, HOLD, RUN, SAMPLE.
- IDLE: `ising_rstn`=0. `start`=1 and `abort`=0 together cause:
  - `done` cleared;
  - R = max(`run_cycles`, 1) latched;
  - counter loaded with RST_CYCLES-1;
  - transition to HOLD.
- HOLD: `ising_rstn`=0. Counter decrements each cycle. At 0: `ising_rstn` registered to 1, counter loaded with R-1, transition to RUN.
- RUN: `ising_rstn`=1. Counter decrements each cycle. At 0: transition to SAMPLE.
- SAMPLE (single-snapshot build):
  - one cycle;
  - last synchronizer stage copied into `spins`;
  - `done`=1;
  - `ising_rstn`=0;
  - transition to IDLE, all on the same edge.
- Timing: with `start` accepted at edge E0:
  - `busy` rises after E0;
  - `ising_rstn` rises after E0+RST_CYCLES;
  - `spins`/`done` update and `busy`/`ising_rstn` fall after E0+RST_CYCLES+R+1.
- `start` while `busy`=1: ignored. Latched R is not changed.
- `abort` in HOLD, RUN or SAMPLE:
  - next state IDLE, `ising_rstn`=0;
  - `done` stays 0;
  - `spins` unchanged.
- `abort` in IDLE: no effect. If `abort` and `start` are asserted in the same cycle, `abort` wins and the run does not start.
- Counter arithmetic is unsigned CNT_W-bit. R=2^CNT_W-1 must complete with no wrap.
- `mat_wready` = `host_wready` AND (state==IDLE). Combinational, zero latency.
- `wr_blocked` is registered high for one cycle after any cycle with `host_wready`=1 and state≠IDLE.
- `done` stays high until the next accepted `start` or reset.
- A reset in the middle of a run returns to IDLE immediately, with all outputs at their reset values.

Optional Feature:
Macro: ISING_MAJORITY_EN.
- Defined:
  - SAMPLE lasts (SAMPLES-1)*SAMPLE_GAP+1 cycles;
  - a snapshot is taken on the first cycle and every SAMPLE_GAP cycles after;
  - each spin has a $clog2(SAMPLES+1)-bit ones counter;
  - on the final snapshot edge, `spins[i]` = (count_i + current bit > SAMPLES/2);
  - `done`=1 and return to IDLE on that edge;
  - `ising_rstn` stays 1 throughout SAMPLE;
  - `abort` during SAMPLE discards the counters;
  - timing: completion edge is E0+RST_CYCLES+R+1+(SAMPLES-1)*SAMPLE_GAP.
- Undefined: single-snapshot behaviour as above; SAMPLES and SAMPLE_GAP are ignored; no counters are built.

Test Plan:
1. Run timing: RST_CYCLES=16, `run_cycles`=100, `start` at E0, `osc_out`=8'hA5 held steady.
   - `ising_rstn` rises after E0+16.
   - `spins`=8'hA5, `done`=1 and `busy`=0 after E0+117.
2. Zero-length run: `run_cycles`=0.
   - Behaves as R=1; `done` after E0+18.
   - A second `start` in RUN is ignored, and timing is unchanged.
3. Abort: `abort` 50 cycles into RUN.
   - `ising_rstn`=0 and `busy`=0 on the next edge.
   - `done`=0; `spins` keeps its previous value.
   - `start`+`abort` in the same IDLE cycle: stays IDLE.
4. Write gating:
   - `host_wready` pulses in IDLE pass to `mat_wready`.
   - Pulses during HOLD/RUN give `mat_wready`=0 and a one-cycle `wr_blocked` on the next edge.
5. Async reset: assert `axi_rstn`=0 mid-RUN, off a clock edge.
   - All outputs go to reset values immediately.
   - After release, a new run completes normally.
6. ISING_MAJORITY_EN (SAMPLES=3, SAMPLE_GAP=4): bit 0 of `osc_out` toggles 1,0,1 across the snapshots, bit 1 toggles 0,1,0.
   - `spins[1:0]`=2'b01.
   - `done` after E0+RST_CYCLES+R+9.
